// File: rtl/cmn_arb_pkg.sv
// rtl/cmn_arb_pkg.sv - shared types and limits for the round-robin lock arbiter
package cmn_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    localparam int ARB_MAX_REQ = 64;

endpackage

// File: rtl/cmn_rr_lock_arb_if.sv
// rtl/cmn_rr_lock_arb_if.sv - requester/output channel bundle of cmn_rr_lock_arb
interface cmn_rr_lock_arb_if #(
    parameter int REQ_NUM    = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int IDX_WIDTH = $clog2(REQ_NUM);

    logic [REQ_NUM-1:0]                 req_vld;
    logic [REQ_NUM-1:0]                 req_last;
    logic [REQ_NUM-1:0][DATA_WIDTH-1:0] req_data;
    logic [REQ_NUM-1:0]                 req_rdy;
    logic                               out_vld;
    logic                               out_last;
    logic [DATA_WIDTH-1:0]              out_data;
    logic [IDX_WIDTH-1:0]               out_idx;
    logic                               out_rdy;
    logic [REQ_NUM-1:0]                 grant_oh;
    logic                               locked;

    modport master (
        input  req_vld, req_last, req_data, out_rdy,
        output req_rdy, out_vld, out_last, out_data, out_idx, grant_oh, locked
    );

    modport slave (
        output req_vld, req_last, req_data, out_rdy,
        input  req_rdy, out_vld, out_last, out_data, out_idx, grant_oh, locked
    );

endinterface

// File: rtl/cmn_onehot2bin2.sv
// rtl/cmn_onehot2bin2.sv - one-hot to binary index; all-zero input yields all ones
module cmn_onehot2bin2 #(
    parameter int ONEHOT_WIDTH = 4,
    parameter int BIN_WIDTH    = $clog2(ONEHOT_WIDTH)
) (
    input  logic [ONEHOT_WIDTH-1:0] onehot,
    output logic [BIN_WIDTH-1:0]    bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < ONEHOT_WIDTH; i++) begin
            if (onehot[i]) begin
                bin = bin | BIN_WIDTH'(i);
            end
        end
        if (onehot == '0) begin
            bin = '1;
        end
    end

endmodule

// File: rtl/cmn_rr_lock_arb.sv
// rtl/cmn_rr_lock_arb.sv - round-robin arbiter with packet lock (CMN_RR_LOCK_ARB_LOCK_EN)
// Grants are combinational from a registered rotating priority pointer.
module cmn_rr_lock_arb
    import cmn_arb_pkg::*;
#(
    parameter int REQ_NUM    = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    cmn_rr_lock_arb_if.master   bus
);

    localparam int IDX_WIDTH = $clog2(REQ_NUM);

    logic [IDX_WIDTH-1:0]   ptr_q;
    logic [IDX_WIDTH-1:0]   ptr_d;
    logic [2*REQ_NUM-1:0]   dbl_vld;
    logic                   rr_hit;
    logic [IDX_WIDTH-1:0]   rr_idx;
    logic                   win_hit;
    logic [IDX_WIDTH-1:0]   win_idx;
    logic [IDX_WIDTH-1:0]   ptr_nxt;
    logic [REQ_NUM-1:0]     grant;
    logic [DATA_WIDTH-1:0]  data_mux;
    logic                   last_mux;
    logic                   accept;

    // Requests below ptr are masked in the low copy, so the first set bit of
    // the doubled vector is the first requester at or after ptr, wrapping.
    always_comb begin
        dbl_vld = {bus.req_vld, bus.req_vld};
        for (int i = 0; i < 2*REQ_NUM; i++) begin
            if (i < int'(ptr_q)) begin
                dbl_vld[i] = 1'b0;
            end
        end
        rr_hit = 1'b0;
        rr_idx = '0;
        for (int i = 2*REQ_NUM-1; i >= 0; i--) begin
            if (dbl_vld[i]) begin
                rr_hit = 1'b1;
                rr_idx = (i >= REQ_NUM) ? IDX_WIDTH'(i - REQ_NUM) : IDX_WIDTH'(i);
            end
        end
    end

    always_comb begin
        grant    = win_hit ? (REQ_NUM'(1) << win_idx) : '0;
        data_mux = '0;
        last_mux = 1'b0;
        for (int i = 0; i < REQ_NUM; i++) begin
            data_mux = data_mux | (bus.req_data[i] & {DATA_WIDTH{grant[i]}});
            last_mux = last_mux | (bus.req_last[i] & grant[i]);
        end
        ptr_nxt = (win_idx == IDX_WIDTH'(REQ_NUM-1)) ? '0 : win_idx + 1'b1;
    end

    assign accept = win_hit & bus.out_rdy;

`ifdef CMN_RR_LOCK_ARB_LOCK_EN
    arb_state_e             state_q;
    arb_state_e             state_d;
    logic [IDX_WIDTH-1:0]   lock_idx_q;
    logic [IDX_WIDTH-1:0]   lock_idx_d;

    always_comb begin
        if (state_q == ARB_LOCKED) begin
            win_idx = lock_idx_q;
            win_hit = bus.req_vld[lock_idx_q];
        end else begin
            win_idx = rr_idx;
            win_hit = rr_hit;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        ptr_d      = ptr_q;
        if (accept) begin
            if (last_mux) begin
                state_d = ARB_IDLE;
                ptr_d   = ptr_nxt;
            end else begin
                state_d    = ARB_LOCKED;
                lock_idx_d = win_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    assign bus.out_last = last_mux;
    assign bus.locked   = (state_q == ARB_LOCKED);
`else
    logic unused_last;

    always_comb begin
        win_idx = rr_idx;
        win_hit = rr_hit;
        ptr_d   = accept ? ptr_nxt : ptr_q;
    end

    assign unused_last  = last_mux;
    assign bus.out_last = 1'b1;
    assign bus.locked   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    cmn_onehot2bin2 #(
        .ONEHOT_WIDTH (REQ_NUM),
        .BIN_WIDTH    (IDX_WIDTH)
    ) u_oh2bin (
        .onehot (grant),
        .bin    (bus.out_idx)
    );

    assign bus.grant_oh = grant;
    assign bus.out_vld  = win_hit;
    assign bus.out_data = data_mux;
    assign bus.req_rdy  = grant & {REQ_NUM{bus.out_rdy}};

endmodule

// File: tb/tb_cmn_rr_lock_arb.sv
// tb/tb_cmn_rr_lock_arb.sv - directed bench for cmn_rr_lock_arb (CMN_RR_LOCK_ARB_LOCK_EN selects lock tests)
module tb_cmn_rr_lock_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cmn_rr_lock_arb_if #(.REQ_NUM(4), .DATA_WIDTH(32)) bus4 ();
    cmn_rr_lock_arb_if #(.REQ_NUM(5), .DATA_WIDTH(32)) bus5 ();

    cmn_rr_lock_arb #(.REQ_NUM(4), .DATA_WIDTH(32)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.master)
    );

    cmn_rr_lock_arb #(.REQ_NUM(5), .DATA_WIDTH(32)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5.master)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step4(input logic [3:0] vld, input logic [3:0] last, input logic rdy);
        @(negedge clk);
        bus4.req_vld  = vld;
        bus4.req_last = last;
        bus4.out_rdy  = rdy;
        #1;
    endtask

    task automatic step5(input logic [4:0] vld, input logic [4:0] last, input logic rdy);
        @(negedge clk);
        bus5.req_vld  = vld;
        bus5.req_last = last;
        bus5.out_rdy  = rdy;
        #1;
    endtask

    task automatic check4(input string tag, input logic [3:0] g, input logic [1:0] idx,
                          input logic [3:0] rdy, input logic lck);
        check({tag, ".grant"}, 64'(bus4.grant_oh), 64'(g));
        check({tag, ".idx"}, 64'(bus4.out_idx), 64'(idx));
        check({tag, ".rdy"}, 64'(bus4.req_rdy), 64'(rdy));
        check({tag, ".vld"}, 64'(bus4.out_vld), 64'(g != 4'b0));
        check({tag, ".locked"}, 64'(bus4.locked), 64'(lck));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) bus4.req_data[i] = 32'hA000 + 32'(i);
        for (int i = 0; i < 5; i++) bus5.req_data[i] = 32'hB000 + 32'(i);
        bus4.req_vld  = '0;
        bus4.req_last = '0;
        bus4.out_rdy  = 1'b0;
        bus5.req_vld  = '0;
        bus5.req_last = '0;
        bus5.out_rdy  = 1'b1;

        // Reset state with no requests
        #12;
        check4("reset", 4'b0000, 2'b11, 4'b0000, 1'b0);
        check("reset.idx5", 64'(bus5.out_idx), 64'd7);
        @(negedge clk);
        rst = 1'b0;

        // All four requesters single-beat: 0,1,2,3,0
        step4(4'hF, 4'hF, 1'b1);
        check4("rr0", 4'b0001, 2'd0, 4'b0001, 1'b0);
        check("rr0.data", 64'(bus4.out_data), 64'h0000A000);
        check("rr0.last", 64'(bus4.out_last), 64'd1);
        step4(4'hF, 4'hF, 1'b1);
        check4("rr1", 4'b0010, 2'd1, 4'b0010, 1'b0);
        check("rr1.data", 64'(bus4.out_data), 64'h0000A001);
        step4(4'hF, 4'hF, 1'b1);
        check4("rr2", 4'b0100, 2'd2, 4'b0100, 1'b0);
        step4(4'hF, 4'hF, 1'b1);
        check4("rr3", 4'b1000, 2'd3, 4'b1000, 1'b0);
        check("rr3.data", 64'(bus4.out_data), 64'h0000A003);
        step4(4'hF, 4'hF, 1'b1);
        check4("rr4", 4'b0001, 2'd0, 4'b0001, 1'b0);
        step4(4'h0, 4'h0, 1'b1);
        check4("rr_idle", 4'b0000, 2'b11, 4'b0000, 1'b0);

`ifdef CMN_RR_LOCK_ARB_LOCK_EN
        // ptr=1: requester 2 sends 3 beats while 0 and 3 wait; out_rdy 1,0,1,1
        step4(4'b1101, 4'b1001, 1'b1);
        check4("pkt2.b0", 4'b0100, 2'd2, 4'b0100, 1'b0);
        check("pkt2.b0.last", 64'(bus4.out_last), 64'd0);
        step4(4'b1101, 4'b1001, 1'b0);
        check4("pkt2.stall", 4'b0100, 2'd2, 4'b0000, 1'b1);
        step4(4'b1101, 4'b1001, 1'b1);
        check4("pkt2.b1", 4'b0100, 2'd2, 4'b0100, 1'b1);
        step4(4'b1101, 4'b1101, 1'b1);
        check4("pkt2.b2", 4'b0100, 2'd2, 4'b0100, 1'b1);
        check("pkt2.b2.last", 64'(bus4.out_last), 64'd1);
        step4(4'b1001, 4'b1001, 1'b1);
        check4("after2.r3", 4'b1000, 2'd3, 4'b1000, 1'b0);
        step4(4'b1001, 4'b1001, 1'b1);
        check4("after2.r0", 4'b0001, 2'd0, 4'b0001, 1'b0);

        // ptr=1: requester 1 locked, drops valid for 2 cycles while 0 waits
        step4(4'b0011, 4'b0001, 1'b1);
        check4("gap.b0", 4'b0010, 2'd1, 4'b0010, 1'b0);
        step4(4'b0001, 4'b0001, 1'b1);
        check4("gap.c1", 4'b0000, 2'b11, 4'b0000, 1'b1);
        step4(4'b0001, 4'b0001, 1'b1);
        check4("gap.c2", 4'b0000, 2'b11, 4'b0000, 1'b1);
        step4(4'b0011, 4'b0001, 1'b1);
        check4("gap.b1", 4'b0010, 2'd1, 4'b0010, 1'b1);
        step4(4'b0011, 4'b0011, 1'b1);
        check4("gap.b2", 4'b0010, 2'd1, 4'b0010, 1'b1);
        check("gap.b2.data", 64'(bus4.out_data), 64'h0000A001);
        step4(4'b0000, 4'b0000, 1'b1);

        // ptr=2: reset during second beat of requester 3's packet
        step4(4'b1000, 4'b0000, 1'b1);
        check4("rst.b0", 4'b1000, 2'd3, 4'b1000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        bus4.req_vld  = 4'b1001;
        bus4.req_last = 4'b0001;
        #1;
        check("rst.mid.locked", 64'(bus4.locked), 64'd0);
        check("rst.mid.grant", 64'(bus4.grant_oh), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check4("rst.after", 4'b0001, 2'd0, 4'b0001, 1'b0);
        step4(4'b0000, 4'b0000, 1'b1);
`else
        // ptr=1: per-beat round-robin ignores last=0
        step4(4'b0110, 4'b0000, 1'b1);
        check4("pb0", 4'b0010, 2'd1, 4'b0010, 1'b0);
        check("pb0.last", 64'(bus4.out_last), 64'd1);
        step4(4'b0110, 4'b0000, 1'b1);
        check4("pb1", 4'b0100, 2'd2, 4'b0100, 1'b0);
        step4(4'b0110, 4'b0000, 1'b1);
        check4("pb2", 4'b0010, 2'd1, 4'b0010, 1'b0);
        step4(4'b0110, 4'b0000, 1'b1);
        check4("pb3", 4'b0100, 2'd2, 4'b0100, 1'b0);
        step4(4'b0110, 4'b0000, 1'b0);
        check4("pb.stall", 4'b0010, 2'd1, 4'b0000, 1'b0);
        step4(4'b0110, 4'b0000, 1'b1);
        check4("pb.resume", 4'b0010, 2'd1, 4'b0010, 1'b0);
        step4(4'b0000, 4'b0000, 1'b1);
`endif

        // REQ_NUM=5 wrap-around: drive ptr to 4, then 4 and 0 alternate
        step5(5'b01000, 5'h1F, 1'b1);
        check("w5.r3", 64'(bus5.grant_oh), 64'b01000);
        step5(5'b10001, 5'h1F, 1'b1);
        check("w5.g0", 64'(bus5.grant_oh), 64'b10000);
        check("w5.i0", 64'(bus5.out_idx), 64'd4);
        check("w5.d0", 64'(bus5.out_data), 64'h0000B004);
        step5(5'b10001, 5'h1F, 1'b1);
        check("w5.g1", 64'(bus5.grant_oh), 64'b00001);
        check("w5.i1", 64'(bus5.out_idx), 64'd0);
        step5(5'b10001, 5'h1F, 1'b1);
        check("w5.g2", 64'(bus5.grant_oh), 64'b10000);
        check("w5.i2", 64'(bus5.out_idx), 64'd4);
        check("w5.rdy2", 64'(bus5.req_rdy), 64'b10000);
        step5(5'b00000, 5'h00, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
